// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing constants for the video path.
// Holds the default 640x480@60 Hz timing, the derived line/frame totals and the
// coordinate width. Pattern generators import this for the active area size.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FRONT_DEF  = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BACK_DEF   = 48;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FRONT_DEF  = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BACK_DEF   = 33;

   // Length of one axis period (pixels per line or lines per frame).
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
      return active + front + sync + back;
   endfunction

   localparam int unsigned H_TOTAL_DEF =
      axis_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
   localparam int unsigned V_TOTAL_DEF =
      axis_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Counts 0..TOTAL-1 when en_i is high and decodes its position within the period.
// Ports:
//   clk_i        pixel clock
//   rst_i        synchronous active-high reset
//   en_i         advance the counter this cycle
//   count_o      current position
//   wrap_o       high while count_o is at the last position of the period
//   in_active_o  high while count_o < ACTIVE
//   in_sync_o    high while count_o is inside the sync pulse
// All outputs are registered; the flags are decoded from the next-state count so
// they line up with count_o.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned FRONT  = H_FRONT_DEF,
   parameter int unsigned SYNC   = H_SYNC_DEF,
   parameter int unsigned BACK   = H_BACK_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   output logic [COORD_W-1:0] count_o,
   output logic               wrap_o,
   output logic               in_active_o,
   output logic               in_sync_o
);

   localparam int unsigned Total     = axis_total(ACTIVE, FRONT, SYNC, BACK);
   localparam int unsigned MaxTotal  = (1 << COORD_W) - 1;
   localparam int unsigned SyncStart = ACTIVE + FRONT;
   localparam int unsigned SyncEnd   = ACTIVE + FRONT + SYNC;

   if (Total > MaxTotal || Total < 2) begin : g_total_check
      $error("vga_axis_counter: axis total out of range");
   end

   localparam logic [COORD_W-1:0] Last      = COORD_W'(Total - 1);
   localparam logic [COORD_W-1:0] ActiveEnd = COORD_W'(ACTIVE);
   localparam logic [COORD_W-1:0] SyncLo    = COORD_W'(SyncStart);
   localparam logic [COORD_W-1:0] SyncHi    = COORD_W'(SyncEnd);

   // Flag values for count == 0, loaded on reset.
   localparam logic RstActive = (ACTIVE != 0);
   localparam logic RstSync   = (SyncStart == 0) && (SYNC != 0);

   logic [COORD_W-1:0] count_d, count_q;
   logic               wrap_d, wrap_q;
   logic               active_d, active_q;
   logic               sync_d, sync_q;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = (count_q == Last) ? '0 : count_q + COORD_W'(1);
      end
      wrap_d   = (count_d == Last);
      active_d = (count_d < ActiveEnd);
      sync_d   = (count_d >= SyncLo) && (count_d < SyncHi);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= '0;
         wrap_q   <= 1'b0;
         active_q <= RstActive;
         sync_q   <= RstSync;
      end else begin
         count_q  <= count_d;
         wrap_q   <= wrap_d;
         active_q <= active_d;
         sync_q   <= sync_d;
      end
   end

   assign count_o     = count_q;
   assign wrap_o      = wrap_q;
   assign in_active_o = active_q;
   assign in_sync_o   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator (default 640x480@60 Hz).
// Ports:
//   clk_i         pixel clock (25 MHz for the default timing)
//   rst_i         synchronous active-high reset
//   x_o / y_o     current pixel column / line
//   active_o      high inside the visible area
//   hsync_o       horizontal sync, active-low
//   vsync_o       vertical sync, active-low
//   next_frame_o  one-cycle strobe on the last pixel of each frame
// Every output is a register or an AND of registers, with no latency relative to
// x_o/y_o; downstream stages must delay the syncs to match their own pipelines.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FRONT  = H_FRONT_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BACK   = H_BACK_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FRONT  = V_FRONT_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BACK   = V_BACK_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   output logic [COORD_W-1:0] x_o,
   output logic [COORD_W-1:0] y_o,
   output logic               active_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               next_frame_o
);

   logic h_wrap, h_active, h_sync;
   logic v_wrap, v_active, v_sync;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h_axis (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (1'b1),
      .count_o     (x_o),
      .wrap_o      (h_wrap),
      .in_active_o (h_active),
      .in_sync_o   (h_sync)
   );

   // The line counter steps on the edge that takes x from its last value back to 0.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v_axis (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (h_wrap),
      .count_o     (y_o),
      .wrap_o      (v_wrap),
      .in_active_o (v_active),
      .in_sync_o   (v_sync)
   );

   assign active_o     = h_active & v_active;
   assign hsync_o      = ~h_sync;
   assign vsync_o      = ~v_sync;
   assign next_frame_o = h_wrap & v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, 800x8 raster, 12x7
// raster) checked every cycle against a time-indexed raster model, plus vector
// tables and multi-cycle sequences for resets, wraps and per-frame statistics.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       a;
      logic       hs;
      logic       vs;
      logic       nf;
   } obs_t;

   typedef struct {
      int unsigned ha, hf, hs, hb, va, vf, vs, vb;
   } timing_t;

   typedef struct {
      int          k;
      int unsigned t;
      obs_t        exp;
   } vec_t;

   logic       clk;
   logic [2:0] rst;
   logic [9:0] x [3];
   logic [9:0] y [3];
   logic       act [3];
   logic       hs [3];
   logic       vs [3];
   logic       nf [3];

   timing_t     cfg [3];
   int unsigned t [3];
   bit          valid [3];
   int          checks;
   int          failures;
   vec_t        vecs [$];

   vga_timing_gen u_full (
      .clk_i(clk), .rst_i(rst[0]), .x_o(x[0]), .y_o(y[0]), .active_o(act[0]),
      .hsync_o(hs[0]), .vsync_o(vs[0]), .next_frame_o(nf[0])
   );

   vga_timing_gen #(
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) u_mid (
      .clk_i(clk), .rst_i(rst[1]), .x_o(x[1]), .y_o(y[1]), .active_o(act[1]),
      .hsync_o(hs[1]), .vsync_o(vs[1]), .next_frame_o(nf[1])
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) u_small (
      .clk_i(clk), .rst_i(rst[2]), .x_o(x[2]), .y_o(y[2]), .active_o(act[2]),
      .hsync_o(hs[2]), .vsync_o(vs[2]), .next_frame_o(nf[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycles since the last reset edge; 0 is the cycle showing the reset state.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst[k]) begin
            t[k]     <= 0;
            valid[k] <= 1'b1;
         end else begin
            t[k] <= t[k] + 1;
         end
      end
   end

   function automatic obs_t mk(input int unsigned xv, input int unsigned yv, input bit a,
                               input bit h, input bit v, input bit n);
      obs_t o;
      o.x  = 10'(xv);
      o.y  = 10'(yv);
      o.a  = a;
      o.hs = h;
      o.vs = v;
      o.nf = n;
      return o;
   endfunction

   function automatic obs_t sample(input int k);
      return mk(x[k], y[k], act[k], hs[k], vs[k], nf[k]);
   endfunction

   // Raster position is simply elapsed time modulo the frame length.
   function automatic obs_t model(input int k, input int unsigned tt);
      timing_t     c;
      int unsigned ht, vt, p, xi, yi;
      bit          a, h, v, n;
      c  = cfg[k];
      ht = c.ha + c.hf + c.hs + c.hb;
      vt = c.va + c.vf + c.vs + c.vb;
      p  = tt % (ht * vt);
      xi = p % ht;
      yi = p / ht;
      a  = (xi < c.ha) && (yi < c.va);
      h  = !((xi >= c.ha + c.hf) && (xi < c.ha + c.hf + c.hs));
      v  = !((yi >= c.va + c.vf) && (yi < c.va + c.vf + c.vs));
      n  = (p == ht * vt - 1);
      return mk(xi, yi, a, h, v, n);
   endfunction

   task automatic check(input string name, input int k, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d t=%0d got x=%0d y=%0d a=%b hs=%b vs=%b nf=%b exp x=%0d y=%0d a=%b hs=%b vs=%b nf=%b",
                  name, k, t[k], got.x, got.y, got.a, got.hs, got.vs, got.nf,
                  exp.x, exp.y, exp.a, exp.hs, exp.vs, exp.nf);
      end
   endtask

   task automatic check_int(input string name, input int k, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s inst=%0d got=%0d exp=%0d", name, k, got, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (valid[k]) check("model", k, sample(k), model(k, t[k]));
      end
   end

   // Leaves the caller on the negedge showing t == 0.
   task automatic do_reset(input int k, input int cycles);
      @(posedge clk);
      #1 rst[k] = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 rst[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_t(input int k, input int unsigned target, output bit ok);
      int n;
      n = 0;
      while (t[k] != target && n < 20000) begin
         @(negedge clk);
         n++;
      end
      ok = (t[k] == target);
      if (!ok) check_int("wait_timeout", k, int'(t[k]), int'(target));
   endtask

   task automatic stats(input string name, input int k, input int cycles, input int e_act,
                        input int e_hlow, input int e_vlow, input int e_nf, input int e_hfall);
      int  n_act, n_hlow, n_vlow, n_nf, n_hfall, n_late;
      bit  prev_hs;
      obs_t o;
      n_act = 0; n_hlow = 0; n_vlow = 0; n_nf = 0; n_hfall = 0; n_late = 0;
      prev_hs = 1'b1;
      do_reset(k, 1);
      for (int i = 0; i < cycles; i++) begin
         o = sample(k);
         if (o.a) n_act++;
         if (o.a && o.y >= 10'(cfg[k].va)) n_late++;
         if (!o.hs) n_hlow++;
         if (!o.vs) n_vlow++;
         if (o.nf) n_nf++;
         if (prev_hs && !o.hs) n_hfall++;
         prev_hs = o.hs;
         @(negedge clk);
      end
      check_int({name, "_active"}, k, n_act, e_act);
      check_int({name, "_active_late"}, k, n_late, 0);
      check_int({name, "_hsync_low"}, k, n_hlow, e_hlow);
      check_int({name, "_vsync_low"}, k, n_vlow, e_vlow);
      check_int({name, "_next_frame"}, k, n_nf, e_nf);
      check_int({name, "_hsync_pulses"}, k, n_hfall, e_hfall);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit ok;
      int n, pulses, pos, k;
      checks   = 0;
      failures = 0;
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
      cfg[1] = '{640, 16, 96, 48, 4, 1, 2, 1};
      cfg[2] = '{8, 1, 2, 1, 4, 1, 1, 1};
      rst = 3'b111;

      vecs.push_back('{0, 0,    mk(0, 0, 1, 1, 1, 0)});
      vecs.push_back('{0, 1,    mk(1, 0, 1, 1, 1, 0)});
      vecs.push_back('{0, 639,  mk(639, 0, 1, 1, 1, 0)});
      vecs.push_back('{0, 640,  mk(640, 0, 0, 1, 1, 0)});
      vecs.push_back('{0, 655,  mk(655, 0, 0, 1, 1, 0)});
      vecs.push_back('{0, 656,  mk(656, 0, 0, 0, 1, 0)});
      vecs.push_back('{0, 751,  mk(751, 0, 0, 0, 1, 0)});
      vecs.push_back('{0, 752,  mk(752, 0, 0, 1, 1, 0)});
      vecs.push_back('{0, 799,  mk(799, 0, 0, 1, 1, 0)});
      vecs.push_back('{0, 800,  mk(0, 1, 1, 1, 1, 0)});
      vecs.push_back('{0, 1439, mk(639, 1, 1, 1, 1, 0)});
      vecs.push_back('{0, 1440, mk(640, 1, 0, 1, 1, 0)});
      vecs.push_back('{1, 4000, mk(0, 5, 0, 1, 0, 0)});
      vecs.push_back('{1, 5599, mk(799, 6, 0, 1, 0, 0)});
      vecs.push_back('{1, 5600, mk(0, 7, 0, 1, 1, 0)});
      vecs.push_back('{1, 6399, mk(799, 7, 0, 1, 1, 1)});
      vecs.push_back('{1, 6400, mk(0, 0, 1, 1, 1, 0)});
      vecs.push_back('{2, 7,    mk(7, 0, 1, 1, 1, 0)});
      vecs.push_back('{2, 8,    mk(8, 0, 0, 1, 1, 0)});
      vecs.push_back('{2, 9,    mk(9, 0, 0, 0, 1, 0)});
      vecs.push_back('{2, 10,   mk(10, 0, 0, 0, 1, 0)});
      vecs.push_back('{2, 11,   mk(11, 0, 0, 1, 1, 0)});
      vecs.push_back('{2, 12,   mk(0, 1, 1, 1, 1, 0)});
      vecs.push_back('{2, 48,   mk(0, 4, 0, 1, 1, 0)});
      vecs.push_back('{2, 60,   mk(0, 5, 0, 1, 0, 0)});
      vecs.push_back('{2, 69,   mk(9, 5, 0, 0, 0, 0)});
      vecs.push_back('{2, 83,   mk(11, 6, 0, 1, 1, 1)});
      vecs.push_back('{2, 84,   mk(0, 0, 1, 1, 1, 0)});

      repeat (2) @(posedge clk);
      #1 rst = 3'b000;
      @(negedge clk);

      foreach (vecs[i]) begin
         k = vecs[i].k;
         if (t[k] > vecs[i].t) do_reset(k, 1);
         wait_t(k, vecs[i].t, ok);
         if (ok) check("vec", k, sample(k), vecs[i].exp);
      end

      // Reset mid-frame, then the count resumes from 1.
      do_reset(0, 1);
      wait_t(0, 1100, ok);
      if (ok) begin
         check("pre_reset", 0, sample(0), mk(300, 1, 1, 1, 1, 0));
         rst[0] = 1'b1;
         @(posedge clk);
         #1 rst[0] = 1'b0;
         @(negedge clk);
         check("mid_reset", 0, sample(0), mk(0, 0, 1, 1, 1, 0));
         for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("resume", 0, sample(0), mk(i, 0, 1, 1, 1, 0));
         end
      end

      // Reset during the last pixel: no extra strobe, next one a full frame later.
      do_reset(2, 1);
      n = 0;
      while (!nf[2] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_int("nf_seen", 2, int'(nf[2]), 1);
      check("nf_pos", 2, sample(2), mk(11, 6, 0, 1, 1, 1));
      rst[2] = 1'b1;
      @(posedge clk);
      #1 rst[2] = 1'b0;
      pulses = 0;
      pos    = -1;
      for (int i = 0; i < 84; i++) begin
         @(negedge clk);
         if (nf[2]) begin
            pulses++;
            if (pos < 0) pos = i;
         end
      end
      check_int("nf_after_reset_count", 2, pulses, 1);
      check_int("nf_after_reset_pos", 2, pos, 83);

      stats("line0", 0, 800, 640, 96, 0, 0, 1);
      stats("midframe", 1, 6400, 2560, 768, 1600, 1, 8);
      stats("smallframe", 2, 84, 32, 14, 12, 1, 7);
      stats("smallframes", 2, 252, 96, 42, 36, 3, 21);

      // Random run lengths and reset pulses; the per-cycle model check covers them.
      for (int it = 0; it < 25; it++) begin
         k = int'($urandom_range(0, 2));
         repeat ($urandom_range(1, 400)) @(negedge clk);
         if ($urandom_range(0, 1) == 1) do_reset(k, int'($urandom_range(1, 3)));
      end
      repeat (100) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
